// File: rtl/multi_window_preproc_pkg.sv
// Shared definitions for the multi-window price preprocessor.
//   DATA_W_DEF   : default unsigned sample width
//   NUM_WIN_DEF  : default number of moving-average windows
//   WIN_LOG2_DEF : default log2 window lengths (4, 8, 16, 32 samples)
//   sum_w()      : width of a running sum over 2^log2 samples of in_w bits
package multi_window_preproc_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int NUM_WIN_DEF = 4;
  localparam int WIN_LOG2_DEF [NUM_WIN_DEF] = '{2, 3, 4, 5};

  // A sum of 2^log2 values of in_w bits never needs more than in_w+log2 bits.
  function automatic int sum_w(int in_w, int log2);
    return in_w + log2;
  endfunction

endpackage

// File: rtl/window_accum.sv
// One moving-sum window: circular buffer of 2^LOG2 samples plus running sum.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   clr      : synchronous history clear (flush)
//   en       : accept din this cycle
//   din      : sample, IN_W bits
//   sum_nxt  : running sum as it will be after this cycle's accept
//   full_nxt : filled flag as it will be after this cycle's accept
// Both outputs describe the post-accept state so the owner can register
// them on the same edge as the accept, giving one cycle of latency.
module window_accum
  import multi_window_preproc_pkg::*;
#(
  parameter int IN_W = 8,
  parameter int LOG2 = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic [IN_W-1:0]             din,
  output logic [sum_w(IN_W,LOG2)-1:0] sum_nxt,
  output logic                        full_nxt
);

  localparam int DEPTH = 1 << LOG2;
  localparam int SUM_W = sum_w(IN_W, LOG2);

  logic [IN_W-1:0]  hist_q [DEPTH];
  logic [LOG2-1:0]  wr_ptr;
  logic [SUM_W-1:0] sum_q;
  logic             full_q;

  // The slot under wr_ptr is the oldest sample; empty slots hold zero, so
  // the subtraction is harmless while the window is still filling.
  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    sum_nxt  = sum_q + SUM_W'(din) - SUM_W'(hist_q[wr_ptr]);
    full_nxt = full_q || (wr_ptr == '1);
  end

  // NOTE: the history buffer is cleared explicitly because empty slots must
  // read as zero; that forces it into flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      wr_ptr <= '0;
      sum_q  <= '0;
      full_q <= 1'b0;
    end else if (en) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      hist_q[wr_ptr] <= din;
      wr_ptr         <= wr_ptr + 1'b1;
      sum_q          <= sum_nxt;
      full_q         <= full_nxt;
    end
  end

endmodule

// File: rtl/multi_window_preproc.sv
// Multi-window moving-average preprocessor for a price stream.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_data   : unsigned sample, DATA_W bits
//   in_valid  : in_data valid
//   in_ready  : sample accepted this cycle when in_valid is also high
//   flush     : clears all window history (wins over in_valid)
//   mean_out  : per-window floor mean, NUM_WIN x DATA_W
//   sq_mean   : floor mean of squared samples over the largest window
//   win_full  : per-window filled flag
//   last_data : most recently accepted sample
//   out_valid : output set valid; held until out_ready
//   out_ready : downstream accepts the output set
module multi_window_preproc
  import multi_window_preproc_pkg::*;
#(
  parameter int DATA_W             = DATA_W_DEF,
  parameter int NUM_WIN            = NUM_WIN_DEF,
  parameter int WIN_LOG2 [NUM_WIN] = WIN_LOG2_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  output logic [NUM_WIN-1:0][DATA_W-1:0]  mean_out,
  output logic [2*DATA_W-1:0]             sq_mean,
  output logic [NUM_WIN-1:0]              win_full,
  output logic [DATA_W-1:0]               last_data,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int SQ_W    = 2 * DATA_W;
  localparam int SQ_LOG2 = WIN_LOG2[NUM_WIN-1];

  logic                           accept;
  logic [SQ_W-1:0]                in_sq;
  logic [NUM_WIN-1:0][DATA_W-1:0] mean_nxt;
  logic [NUM_WIN-1:0]             full_nxt;
  logic [SQ_W-1:0]                sq_nxt;
  logic [sum_w(SQ_W,SQ_LOG2)-1:0] sq_sum_nxt;
  logic                           sq_full_unused;

  // A new sample is taken only when the held output set can be replaced.
  assign in_ready = !rst && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign in_sq    = SQ_W'(in_data) * SQ_W'(in_data);

  for (genvar g = 0; g < NUM_WIN; g++) begin : g_win
    localparam int L = WIN_LOG2[g];
    logic [sum_w(DATA_W,L)-1:0] sum_nxt;

    window_accum #(.IN_W(DATA_W), .LOG2(L)) u_accum (
      .clk      (clk),
      .rst      (rst),
      .clr      (flush),
      .en       (accept),
      .din      (in_data),
      .sum_nxt  (sum_nxt),
      .full_nxt (full_nxt[g])
    );

    assign mean_nxt[g] = DATA_W'(sum_nxt >> L);
  end

  window_accum #(.IN_W(SQ_W), .LOG2(SQ_LOG2)) u_sq_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .en       (accept),
    .din      (in_sq),
    .sum_nxt  (sq_sum_nxt),
    .full_nxt (sq_full_unused)
  );

  assign sq_nxt = SQ_W'(sq_sum_nxt >> SQ_LOG2);

  // Output register: loads only on accept, so a stalled set stays frozen.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mean_out  <= '0;
      sq_mean   <= '0;
      win_full  <= '0;
      last_data <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      mean_out  <= mean_nxt;
      sq_mean   <= sq_nxt;
      win_full  <= full_nxt;
      last_data <= in_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_window_preproc.sv
// Self-checking bench for multi_window_preproc (default parameters).
module tb_multi_window_preproc;

  typedef struct packed {
    logic [3:0][7:0] mean;
    logic [15:0]     sq;
    logic [3:0]      full;
    logic [7:0]      last;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      in_data;
  logic            in_valid;
  logic            in_ready;
  logic            flush;
  logic [3:0][7:0] mean_out;
  logic [15:0]     sq_mean;
  logic [3:0]      win_full;
  logic [7:0]      last_data;
  logic            out_valid;
  logic            out_ready;

  int   n_cmp = 0;
  int   n_err = 0;
  int   wl [4] = '{2, 3, 4, 5};
  int   hist [$];
  int   fill_cnt = 0;
  bit   m_ov = 0;
  exp_t m_out = '0;
  exp_t sb_q [$];

  multi_window_preproc dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .mean_out  (mean_out),
    .sq_mean   (sq_mean),
    .win_full  (win_full),
    .last_data (last_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: explicit sums over the accepted-sample history.
  function automatic exp_t model();
    exp_t e;
    int   n, len, s, sq;
    e = '0;
    n = hist.size();
    for (int w = 0; w < 4; w++) begin
      len = 1 << wl[w];
      s = 0;
      for (int k = 0; k < len && k < n; k++) s += hist[n-1-k];
      e.mean[w] = 8'(s >> wl[w]);
      e.full[w] = (fill_cnt >= len);
    end
    sq = 0;
    for (int k = 0; k < 32 && k < n; k++) sq += hist[n-1-k] * hist[n-1-k];
    e.sq   = 16'(sq >> 5);
    e.last = (n > 0) ? 8'(hist[n-1]) : 8'd0;
    return e;
  endfunction

  task automatic compare_set(input string tag, input exp_t e);
    check({tag, "_mean"}, mean_out, e.mean);
    check({tag, "_sq"},   sq_mean,  e.sq);
    check({tag, "_full"}, win_full, e.full);
    check({tag, "_last"}, last_data, e.last);
  endtask

  // One clock: inputs already driven after a negedge; model the edge,
  // then compare just after it.
  task automatic step();
    bit   acc, cleared;
    exp_t e;
    #1;
    check("in_ready", in_ready, !rst && !flush && (!m_ov || out_ready));
    acc     = in_valid && !rst && !flush && (!m_ov || out_ready);
    cleared = rst || flush;
    if (cleared) begin
      hist.delete();
      fill_cnt = 0;
      m_ov     = 0;
      m_out    = '0;
    end else if (acc) begin
      hist.push_back(int'(in_data));
      if (hist.size() > 32) void'(hist.pop_front());
      fill_cnt++;
      m_out = model();
      m_ov  = 1;
      sb_q.push_back(m_out);
    end else if (out_ready) begin
      m_ov = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      compare_set("acc", e);
    end else if (cleared || m_ov) begin
      compare_set(cleared ? "clr" : "hold", m_out);
    end
  endtask

  task automatic drive(input bit v, input int d, input bit rdy, input bit fl, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_data   = 8'(d);
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    step();
  endtask

  initial begin
    rst = 1; in_data = 0; in_valid = 0; flush = 0; out_ready = 1;
    drive(1, 55, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    check("rst_out_valid", out_valid, 0);

    // Four samples of 100.
    for (int i = 0; i < 4; i++) drive(1, 100, 1, 0, 0);
    check("c1_mean0", mean_out[0], 100);
    check("c1_mean1", mean_out[1], 50);
    check("c1_full",  win_full, 4'b0001);
    check("c1_sq",    sq_mean, 1250);

    // Ramp 0..31 from a clean history.
    drive(0, 0, 1, 1, 0);
    for (int i = 0; i < 32; i++) drive(1, i, 1, 0, 0);
    check("ramp_mean3", mean_out[3], 15);
    check("ramp_mean0", mean_out[0], 29);
    check("ramp_full",  win_full, 4'b1111);

    // Saturating-value run: widest sums must not overflow.
    for (int i = 0; i < 32; i++) drive(1, 255, 1, 0, 0);
    check("max_means", mean_out, {4{8'd255}});
    check("max_sq",    sq_mean, 65025);

    // Backpressure: three stalled cycles, then resume.
    for (int i = 0; i < 3; i++) drive(1, 9, 0, 0, 0);
    drive(1, 7, 1, 0, 0);
    check("stall_last", last_data, 7);

    // Flush with a sample presented, after 10 accepts.
    for (int i = 0; i < 10; i++) drive(1, 3 * i + 1, 1, 0, 0);
    drive(1, 200, 1, 1, 0);
    check("flush_valid", out_valid, 0);
    check("flush_zero",  {mean_out, sq_mean, win_full, last_data}, '0);
    for (int i = 0; i < 4; i++) drive(1, 8, 1, 0, 0);
    check("flush_mean0", mean_out[0], 8);

    // Flush while an output set is pending and stalled.
    drive(1, 40, 0, 0, 0);
    drive(1, 41, 0, 1, 0);
    check("pend_flush_valid", out_valid, 0);

    // Reset mid-stream with a sample presented.
    for (int i = 0; i < 5; i++) drive(1, 60 + i, 1, 0, 0);
    drive(1, 99, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 20, 1, 0, 0);
    check("rst_mean0", mean_out[0], 20);

    // Randomized traffic with random backpressure and occasional flush.
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 255),
            $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_window_preproc.md
MULTI_WINDOW_PREPROC -- requirements
Module: multi_window_preproc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the unsigned sample width.
REQ-002 SHALL have parameter NUM_WIN, default 4, meaning the number of moving-average windows.
REQ-003 SHALL have parameter WIN_LOG2[NUM_WIN], default {2,3,4,5}, meaning log2 of each window length (lengths 4, 8, 16, 32); values SHALL be strictly increasing.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, DATA_W bits: the incoming price sample.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 SHALL have port flush, input, 1 bit: clears all window history.
REQ-010 SHALL have port mean_out, output, NUM_WIN x DATA_W bits: the per-window mean.
REQ-011 SHALL have port sq_mean, output, 2*DATA_W bits: the mean of squared samples over the largest window.
REQ-012 SHALL have port win_full, output, NUM_WIN bits: the per-window filled flag.
REQ-013 SHALL have port last_data, output, DATA_W bits: the most recently accepted sample.
REQ-014 SHALL have port out_valid, output, 1 bit: the output set is valid.
REQ-015 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the output set.

Function
REQ-016 Accept SHALL occur when in_valid && in_ready; in_ready = !flush && (!out_valid || out_ready).
REQ-017 Each window i SHALL hold a circular buffer of 2^WIN_LOG2[i] samples and a running sum of width DATA_W+WIN_LOG2[i].
REQ-018 On accept, the window SHALL update sum = sum + new - oldest and overwrite the oldest entry; the write pointer wraps modulo the window length.
REQ-019 mean_out[i] SHALL equal sum_i >> WIN_LOG2[i] (floor).
REQ-020 Empty buffer slots SHALL count as zero, so before a window fills, its mean is biased low.
REQ-021 win_full[i] SHALL rise on the accept that completes 2^WIN_LOG2[i] samples since reset or flush, and stay high until reset or flush.
REQ-022 sq_mean SHALL equal the floor of (the sum of in_data^2 over the largest window) >> WIN_LOG2[NUM_WIN-1].
REQ-023 The squared-sample sum SHALL be 2*DATA_W+WIN_LOG2[NUM_WIN-1] bits wide, with no overflow or saturation.
REQ-024 Latency SHALL be 1 cycle: an accept at edge t produces updated outputs and out_valid=1 after edge t.
REQ-025 out_valid SHALL clear on out_ready && !accept.
REQ-026 While out_valid && !out_ready, every output SHALL hold stable.
REQ-027 flush SHALL take priority over in_valid; the sample presented in the flush cycle is not accepted.
REQ-028 On flush, the block SHALL zero all buffers, sums, pointers, win_full, mean_out, sq_mean, last_data and out_valid on the next edge.
REQ-029 Flush while out_valid=1 SHALL discard the pending output set.

Reset
REQ-030 While rst=1 at an edge, the block SHALL clear all buffers, sums, pointers and fill counters.
REQ-031 Reset values SHALL be: mean_out=0, sq_mean=0, win_full=0, last_data=0, out_valid=0.
REQ-032 in_ready SHALL be 0 during reset; a sample presented with rst=1 SHALL be dropped.
REQ-033 rst SHALL override flush and any in-progress accept.

Structure
REQ-034 A shared package SHALL hold the default WIN_LOG2 array, DATA_W_DEF, and a sum-width helper function.
REQ-035 The block SHALL use one sub-module, window_accum: parameters IN_W and LOG2, containing the circular buffer, running sum and full flag.
REQ-036 The block SHALL instantiate window_accum NUM_WIN times on in_data and once on in_data^2 with IN_W=2*DATA_W.
REQ-037 The output register stage and the handshake SHALL live in the top level.

Verification
REQ-038 Reset, then 4 accepts of 100 with out_ready=1 SHALL give mean_out[0]=100, mean_out[1]=50, win_full=0001, sq_mean=1250.
REQ-039 A ramp of 0..31 SHALL give, after the 32nd accept, mean_out[3]=15, mean_out[0]=29, win_full=1111.
REQ-040 32 accepts of 255 SHALL give all means=255 and sq_mean=65025 (no overflow).
REQ-041 With out_ready=0 for 3 cycles after a valid output, in_ready=0, outputs SHALL be frozen and no sample is consumed; after out_ready=1 the next sample SHALL be accepted.
REQ-042 Flush asserted with in_valid=1 after 10 samples SHALL give out_valid=0 and all-zero outputs next cycle; then 4 accepts of 8 SHALL give mean_out[0]=8.
REQ-043 rst=1 asserted mid-stream with in_valid=1 SHALL drop the sample; after release, 4 accepts of 20 SHALL give mean_out[0]=20.
